// File: rtl/motor_update_sched.sv
// motor_update_sched: frame scheduler that clamps four motor speeds and writes them to the pwm instances one at a time
module motor_update_sched #(
    parameter logic [15:0] SPEED_MIN  = 16'd1000,
    parameter logic [15:0] SPEED_MAX  = 16'd60000,
    parameter logic [15:0] IDLE_SPEED = 16'd0,
    parameter logic [31:0] TIMEOUT    = 32'd2_000_000,
    parameter logic [15:0] BUSY_MAX   = 16'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_speed,
    input  logic        arm_req,
    input  logic        disarm_req,
    input  logic [3:0]  busy,
    output logic [15:0] speed_out,
    output logic [3:0]  speed_oe,
    output logic        frame_done,
    output logic        armed,
    output logic        failsafe,
    output logic [3:0]  skip_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][15:0] spd_q, spd_d;
    logic [15:0]      wait_q, wait_d;
    logic [31:0]      timer_q, timer_d;
    logic             armed_q, armed_d;
    logic             failsafe_q, failsafe_d;
    logic [3:0]       skip_q, skip_d;
    logic             stop_pend_q, stop_pend_d;
    logic             rdy_q, rdy_d;
    logic [15:0]      speed_out_q, speed_out_d;
    logic [3:0]       speed_oe_q, speed_oe_d;
    logic             frame_done_q, frame_done_d;
    logic             timeout;
    logic             accept;
    logic             skip_now;

    // Disarmed frames still run, but every motor gets the idle speed.
    function automatic logic [15:0] eff_speed(input logic [15:0] c, input logic arm);
        return !arm ? IDLE_SPEED : (c < SPEED_MIN) ? SPEED_MIN : (c > SPEED_MAX) ? SPEED_MAX : c;
    endfunction

    // The timeout cycle blocks acceptance so a late frame cannot race the failsafe.
    assign timeout    = armed_q && (timer_q == TIMEOUT - 32'd1);
    assign cmd_ready  = rdy_q && !timeout;
    assign accept     = cmd_valid && cmd_ready;
    assign skip_now   = busy[idx_q] && (wait_q == BUSY_MAX - 16'd1);
    assign speed_out  = speed_out_q;
    assign speed_oe   = speed_oe_q;
    assign frame_done = frame_done_q;
    assign armed      = armed_q;
    assign failsafe   = failsafe_q;
    assign skip_err   = skip_q;

    // Frame sequencing followed by arming/failsafe overrides, disarm having the last word.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        spd_d        = spd_q;
        wait_d       = wait_q;
        stop_pend_d  = stop_pend_q;
        skip_d       = skip_q;
        speed_out_d  = speed_out_q;
        speed_oe_d   = 4'b0000;
        frame_done_d = 1'b0;
        armed_d      = armed_q;
        failsafe_d   = failsafe_q;
        timer_d      = (!armed_q || accept) ? 32'd0 : timer_q + 32'd1;
        if (state_q == S_IDLE) begin
            if (stop_pend_q) begin
                spd_d       = {4{IDLE_SPEED}};
                stop_pend_d = 1'b0;
                idx_d       = 2'd0;
                state_d     = S_ISSUE;
            end else if (accept) begin
                for (int i = 0; i < 4; i++) spd_d[i] = eff_speed(cmd_speed[16*i +: 16], armed_q);
                idx_d   = 2'd0;
                state_d = S_ISSUE;
            end
        end else if (state_q == S_ISSUE) begin
            if (!busy[idx_q]) begin
                speed_out_d = spd_q[idx_q];
                speed_oe_d  = 4'b0001 << idx_q;
                wait_d      = 16'd0;
            end else if (skip_now) begin
                skip_d[idx_q] = 1'b1;
                wait_d        = 16'd0;
            end else begin
                wait_d = wait_q + 16'd1;
            end
            if (!busy[idx_q] || skip_now) begin
                idx_d   = idx_q + 2'd1;
                state_d = (idx_q == 2'd3) ? S_DONE : S_ISSUE;
            end
        end else begin
            frame_done_d = 1'b1;
            state_d      = S_IDLE;
        end
        if (timeout) begin
            failsafe_d  = 1'b1;
            armed_d     = 1'b0;
            stop_pend_d = 1'b1;
            timer_d     = 32'd0;
        end
        if (arm_req && !disarm_req) begin
            armed_d    = 1'b1;
            failsafe_d = 1'b0;
            skip_d     = 4'b0000;
            timer_d    = 32'd0;
        end
        if (disarm_req) begin
            armed_d     = 1'b0;
            stop_pend_d = 1'b1;
            timer_d     = 32'd0;
        end
    end

    // Ready is registered and only rises after a full idle cycle with no stop pending.
    always_comb begin
        rdy_d = (state_q == S_IDLE) && (state_d == S_IDLE) && !stop_pend_d;
    end

    // State registers; reset aborts any frame and queues a stop frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            spd_q        <= '0;
            wait_q       <= 16'd0;
            timer_q      <= 32'd0;
            armed_q      <= 1'b0;
            failsafe_q   <= 1'b0;
            skip_q       <= 4'b0000;
            stop_pend_q  <= 1'b1;
            rdy_q        <= 1'b0;
            speed_out_q  <= 16'd0;
            speed_oe_q   <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            spd_q        <= spd_d;
            wait_q       <= wait_d;
            timer_q      <= timer_d;
            armed_q      <= armed_d;
            failsafe_q   <= failsafe_d;
            skip_q       <= skip_d;
            stop_pend_q  <= stop_pend_d;
            rdy_q        <= rdy_d;
            speed_out_q  <= speed_out_d;
            speed_oe_q   <= speed_oe_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: doc/motor_update_sched.md
Name: motor_update_sched

Overview:
- Frame-level scheduler for the four per-motor pwm instances of the quadcopter.
- Accepts a 4-motor speed frame from the flight controller and clamps each speed.
- Writes the speeds one motor at a time over a shared speed bus, using a one-hot load strobe and honouring each pwm's busy.
- Owns arming state and the command-loss failsafe: with no fresh frame, all motors are forced to IDLE_SPEED.

Parameters:
SPEED_MIN, 16'd1000, lower clamp for armed speeds
SPEED_MAX, 16'd60000, upper clamp for armed speeds
IDLE_SPEED, 16'd0, speed written when disarmed, on failsafe and after reset
TIMEOUT, 32'd2_000_000, cycles without an accepted frame (while armed) before failsafe (20 ms at 100 MHz)
BUSY_MAX, 16'd1023, cycles to wait on one motor's busy before skipping it

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  frame valid
cmd_ready  out  1  scheduler can accept a frame
cmd_speed  in  64  motor0 in [15:0] ... motor3 in [63:48], unsigned
arm_req  in  1  one-cycle pulse: arm, clear failsafe
disarm_req  in  1  one-cycle pulse: disarm
busy  in  4  busy from pwm instance i
speed_out  out  16  shared speed bus to all pwm speed_in
speed_oe  out  4  one-hot load strobe, bit i to pwm i speed_oe
frame_done  out  1  one-cycle pulse after the last motor of a frame
armed  out  1  armed state
failsafe  out  1  sticky until arm_req
skip_err  out  4  sticky: motor i was skipped on busy timeout; cleared on arm_req

Behaviour:
- Reset values (the cycle after rst is sampled high): speed_out=0, speed_oe=0, frame_done=0, armed=0, failsafe=0, skip_err=0, cmd_ready=0, state=IDLE, stop_pend=1.
  - The first action after reset is therefore a stop frame.
  - rst mid-frame aborts the frame immediately; no further strobe is issued for it.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - cmd_ready = (state==IDLE) & ~stop_pend.
  - If stop_pend: latch all four speeds = IDLE_SPEED, clear stop_pend, idx=0, go to ISSUE.
  - Else if cmd_valid & cmd_ready: latch effective speeds, idx=0, go to ISSUE.
  - Effective speed: if armed, min(max(cmd,SPEED_MIN),SPEED_MAX); otherwise IDLE_SPEED.
- ISSUE (motor idx):
  - If busy[idx]==0: for exactly one cycle, drive speed_out=spd[idx] and speed_oe=1<<idx; clear the wait counter.
    - If idx==3, go to DONE; otherwise idx+1 and stay in ISSUE.
  - If busy[idx]==1: hold speed_oe=0 and increment the wait counter.
    - When the counter reaches BUSY_MAX, set skip_err[idx] and advance as above without a strobe.
  - speed_out holds its last driven value between strobes.
- DONE: frame_done=1 for one cycle, then IDLE.
- Latency, all busy low: frame accepted at edge N, speed_oe = 0001/0010/0100/1000 at cycles N+1..N+4, frame_done at N+5, cmd_ready high again at N+6.
- Arming:
  - arm_req: armed=1, failsafe=0, skip_err=0, timer=0.
  - disarm_req: armed=0, stop_pend=1.
  - arm_req and disarm_req in the same cycle: disarm wins; failsafe and skip_err are unchanged.
  - Arm/disarm take effect in any state. A frame in progress completes with its latched speeds; the stop frame follows from IDLE.
- Failsafe timer:
  - 32-bit; counts only while armed; cleared on every accepted frame and whenever disarmed.
  - On reaching TIMEOUT: failsafe=1, armed=0, stop_pend=1, timer cleared.
  - A frame accepted in the same cycle as the timeout: the timeout wins and the frame is not accepted (cmd_ready is low that cycle).
- Frames received while disarmed are accepted, and all four motors are written with IDLE_SPEED.

Test Plan:
- Reset, all busy=0 -> stop frame: speed_oe pulses 0001..1000 with speed_out=0, then frame_done; cmd_ready=1 afterwards; armed=0.
- arm_req, then frame {60000+500 clamped?: 65000, 30000, 500, 1000} -> speed_out 60000, 30000, 1000, 1000 on oe bits 0..3, at exactly cycles N+1..N+4; frame_done at N+5.
- Frame while disarmed, cmd 56000 on all motors -> all four writes are 0; armed stays 0.
- busy[2] held high for 10 cycles -> oe2 asserts on the first cycle busy[2]=0; skip_err=0. busy[2] stuck high -> motor 2 skipped after BUSY_MAX cycles, skip_err=0100, motor 3 still written, frame_done pulses.
- Armed, no frame for TIMEOUT (set TIMEOUT=100 in bench) -> failsafe=1 and armed=0 at cycle 100, followed by a stop frame of zeros; arm_req clears failsafe.
- rst asserted during ISSUE at idx=1 -> next cycle speed_oe=0 and armed=0; the stop frame runs after rst is released. Same-cycle arm_req+disarm_req -> armed=0 and stop_pend set.
